// File: rtl/meter_pkg.sv
// Shared state encoding, default widths and switch field positions for the
// parking-meter session controller.
package meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } meter_state_t;

    localparam int SEC_W_DEF  = 12;
    localparam int COST_W_DEF = 14;

    // sw[7:5] = location, sw[4:0] = hour of day
    localparam int LOC_HI  = 7;
    localparam int LOC_LO  = 5;
    localparam int HOUR_HI = 4;
    localparam int HOUR_LO = 0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops at MAX instead of wrapping.
module sat_counter #(
    parameter int W   = 12,
    parameter int MAX = 4095
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/meter_session_ctrl.sv
// Parking-session sequencer: latches the switch setting, counts seconds,
// then waits for the cost converter to settle before capturing the final cost.
module meter_session_ctrl
    import meter_pkg::*;
#(
    parameter int SEC_W      = SEC_W_DEF,
    parameter int COST_W     = COST_W_DEF,
    parameter int MAX_SEC    = 4095,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_clear,
    input  logic [7:0]        sw,
    output logic [7:0]        conv_sw,
    output logic [SEC_W-1:0]  sec_count,
    input  logic [COST_W-1:0] cost_in,
    output logic [COST_W-1:0] cost_live,
    output logic [COST_W-1:0] cost_final,
    output logic [1:0]        state,
    output logic              done,
    output logic              overflow
);

    meter_state_t cur_st, nxt_st;
    logic [3:0]   settle_cnt;
    logic         start_sess, cnt_clr, cnt_en, hit_max;
    logic         ovf_set, settle_load, capture;
    logic         at_max;

    sat_counter #(
        .W   (SEC_W),
        .MAX (MAX_SEC)
    ) u_sec (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clr),
        .en     (cnt_en),
        .count  (sec_count),
        .at_max (at_max)
    );

    assign cost_live = cost_in;
    assign state     = cur_st;
    assign done      = (cur_st == ST_DONE);

    // The tick is counted on the same edge a stop is honoured, so the
    // saturation check looks one count ahead.
    assign hit_max = at_max || (tick_1hz && (sec_count == SEC_W'(MAX_SEC - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st <= ST_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st      = cur_st;
        start_sess  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        ovf_set     = 1'b0;
        settle_load = 1'b0;
        capture     = 1'b0;
        if (btn_clear) begin
            nxt_st  = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (cur_st)
                ST_IDLE, ST_DONE: begin
                    if (btn_start) begin
                        nxt_st     = ST_RUN;
                        start_sess = 1'b1;
                        cnt_clr    = 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_en = tick_1hz;
                    if (hit_max) begin
                        ovf_set     = 1'b1;
                        settle_load = 1'b1;
                        nxt_st      = ST_SETTLE;
                    end else if (btn_stop) begin
                        settle_load = 1'b1;
                        nxt_st      = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        capture = 1'b1;
                        nxt_st  = ST_DONE;
                    end
                end
                default: nxt_st = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_sw    <= '0;
            settle_cnt <= '0;
            cost_final <= '0;
            overflow   <= 1'b0;
        end else begin
            if (btn_clear) begin
                settle_cnt <= '0;
                cost_final <= '0;
                overflow   <= 1'b0;
            end else begin
                if (start_sess) begin
                    conv_sw    <= sw;
                    cost_final <= '0;
                    overflow   <= 1'b0;
                end
                if (ovf_set) begin
                    overflow <= 1'b1;
                end
                if (settle_load) begin
                    settle_cnt <= 4'(SETTLE_CYC - 1);
                end else if (cur_st == ST_SETTLE && settle_cnt != '0) begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
                if (capture) begin
                    cost_final <= cost_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_meter_session_ctrl.sv
// Directed bench for meter_session_ctrl with a behavioural cost converter stub.
module tb_meter_session_ctrl;
    import meter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start1 = 1'b0, stop1 = 1'b0, clear1 = 1'b0;
    logic        start2 = 1'b0, stop2 = 1'b0, clear2 = 1'b0;
    logic [7:0]  sw = 8'h00;

    logic [7:0]  conv_sw1, conv_sw2;
    logic [11:0] sec1, sec2;
    logic [13:0] cost_in1, cost_in2, live1, live2, cf1, cf2;
    logic [1:0]  st1, st2;
    logic        done1, done2, ovf1, ovf2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Converter stub: whole minutes rounded up, times (hour rate + location).
    function automatic logic [13:0] conv_stub(logic [7:0] s, logic [11:0] sec);
        int mins, hr, loc, rate;
        mins = (int'(sec) + 59) / 60;
        hr   = int'(s[HOUR_HI:HOUR_LO]);
        loc  = int'(s[LOC_HI:LOC_LO]);
        rate = (hr >= 8 && hr < 18) ? 2 : 1;
        return 14'(mins * (rate + loc));
    endfunction

    assign cost_in1 = conv_stub(conv_sw1, sec1);
    assign cost_in2 = conv_stub(conv_sw2, sec2);

    meter_session_ctrl #(
        .SEC_W(12), .COST_W(14), .MAX_SEC(4095), .SETTLE_CYC(2)
    ) dut1 (
        .clk(clk), .rst(rst), .tick_1hz(tick),
        .btn_start(start1), .btn_stop(stop1), .btn_clear(clear1),
        .sw(sw), .conv_sw(conv_sw1), .sec_count(sec1), .cost_in(cost_in1),
        .cost_live(live1), .cost_final(cf1), .state(st1), .done(done1),
        .overflow(ovf1)
    );

    meter_session_ctrl #(
        .SEC_W(12), .COST_W(14), .MAX_SEC(10), .SETTLE_CYC(2)
    ) dut2 (
        .clk(clk), .rst(rst), .tick_1hz(tick),
        .btn_start(start2), .btn_stop(stop2), .btn_clear(clear2),
        .sw(sw), .conv_sw(conv_sw2), .sec_count(sec2), .cost_in(cost_in2),
        .cost_live(live2), .cost_final(cf2), .state(st2), .done(done2),
        .overflow(ovf2)
    );

    typedef struct {
        logic       start, stop, clear, tk;
        logic [7:0] swv;
        int         st, sec, dn, conv, cf;
    } vec_t;

    function automatic vec_t mk(logic a, logic b, logic c, logic d, logic [7:0] s,
                                int st, int sec, int dn, int conv, int cf);
        vec_t v;
        v.start = a; v.stop = b; v.clear = c; v.tk = d; v.swv = s;
        v.st = st; v.sec = sec; v.dn = dn; v.conv = conv; v.cf = cf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One stub 1 Hz period: tick high for one cycle, then three quiet cycles.
    task automatic tick_period();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic pulse1(input int which);
        if (which == 0) start1 = 1'b1;
        if (which == 1) stop1  = 1'b1;
        if (which == 2) clear1 = 1'b1;
        cyc();
        start1 = 1'b0; stop1 = 1'b0; clear1 = 1'b0;
    endtask

    vec_t tbl[16];

    initial begin
        // Case 4/6 table, starting from DONE with conv_sw=03, sec=120.
        tbl[0]  = mk(0,0,1,0, 8'h03, 0,   0, 0, 8'h03, 0); // clear from DONE
        tbl[1]  = mk(0,1,0,0, 8'h03, 0,   0, 0, 8'h03, 0); // stop in IDLE ignored
        tbl[2]  = mk(1,1,0,0, 8'h03, 1,   0, 0, 8'h03, 0); // start+stop -> RUN
        tbl[3]  = mk(0,0,0,1, 8'h03, 1,   1, 0, 8'h03, 0);
        tbl[4]  = mk(1,0,0,0, 8'h03, 1,   1, 0, 8'h03, 0); // start in RUN ignored
        tbl[5]  = mk(0,0,0,1, 8'h03, 1,   2, 0, 8'h03, 0);
        tbl[6]  = mk(0,0,0,1, 8'h03, 1,   3, 0, 8'h03, 0);
        tbl[7]  = mk(0,0,0,1, 8'h03, 1,   4, 0, 8'h03, 0);
        tbl[8]  = mk(0,0,0,1, 8'h03, 1,   5, 0, 8'h03, 0);
        tbl[9]  = mk(0,1,0,1, 8'h03, 2,   6, 0, 8'h03, 0); // tick+stop at 5
        tbl[10] = mk(0,0,0,1, 8'h03, 2,   6, 0, 8'h03, 0); // tick in SETTLE ignored
        tbl[11] = mk(1,0,0,0, 8'h03, 3,   6, 1, 8'h03, 1); // capture, start ignored
        tbl[12] = mk(0,0,0,0, 8'h03, 3,   6, 1, 8'h03, 1);
        tbl[13] = mk(1,0,0,0, 8'h2A, 1,   0, 0, 8'h2A, 0); // restart from DONE
        tbl[14] = mk(0,0,0,1, 8'h2A, 1,   1, 0, 8'h2A, 0);
        tbl[15] = mk(1,0,1,0, 8'h55, 0,   0, 0, 8'h2A, 0); // clear beats start

        // Reset state
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_state",  st1, 0);
        chk("rst_sec",    sec1, 0);
        chk("rst_convsw", conv_sw1, 0);
        chk("rst_cf",     cf1, 0);
        chk("rst_done",   done1, 0);
        chk("rst_ovf",    ovf1, 0);
        chk("rst_ovf2",   ovf2, 0);

        // Case 1: normal session, 61 s at 9 am
        sw = 8'b000_01001;
        pulse1(0);
        chk("c1_run",    st1, 1);
        chk("c1_convsw", conv_sw1, 8'h09);
        repeat (61) tick_period();
        chk("c1_sec",  sec1, 61);
        chk("c1_live", live1, 4);
        pulse1(1);
        chk("c1_settle", st1, 2);
        cyc();
        chk("c1_done_early", done1, 0);
        cyc();
        chk("c1_done", done1, 1);
        chk("c1_state_done", st1, 3);
        chk("c1_cf", cf1, 4);

        // Case 2: exact two minutes, switches wiggle mid-run
        sw = 8'b000_00011;
        pulse1(0);
        chk("c2_cf_cleared", cf1, 0);
        repeat (60) tick_period();
        sw = 8'hFF;
        repeat (60) tick_period();
        chk("c2_convsw", conv_sw1, 8'h03);
        chk("c2_sec", sec1, 120);
        sw = 8'h03;
        pulse1(1);
        repeat (2) cyc();
        chk("c2_done", done1, 1);
        chk("c2_cf", cf1, 2);

        // Cases 4 and 6: per-cycle vectors
        for (int i = 0; i < 16; i++) begin
            start1 = tbl[i].start; stop1 = tbl[i].stop;
            clear1 = tbl[i].clear; tick = tbl[i].tk; sw = tbl[i].swv;
            cyc();
            start1 = 1'b0; stop1 = 1'b0; clear1 = 1'b0; tick = 1'b0;
            chk($sformatf("v%0d_state", i), st1, tbl[i].st);
            chk($sformatf("v%0d_sec", i), sec1, tbl[i].sec);
            chk($sformatf("v%0d_done", i), done1, tbl[i].dn);
            chk($sformatf("v%0d_convsw", i), conv_sw1, tbl[i].conv);
            chk($sformatf("v%0d_cf", i), cf1, tbl[i].cf);
        end

        // Case 5a: clear during SETTLE aborts the capture
        sw = 8'h09;
        pulse1(0);
        repeat (3) tick_period();
        pulse1(1);
        chk("c5_settle", st1, 2);
        pulse1(2);
        chk("c5_clr_state", st1, 0);
        chk("c5_clr_sec", sec1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("c5_nodone%0d", i), done1, 0);
        end
        chk("c5_clr_cf", cf1, 0);

        // Case 5b: reset mid-run
        pulse1(0);
        repeat (30) tick_period();
        chk("c5_sec30", sec1, 30);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("c5_rst_state",  st1, 0);
        chk("c5_rst_sec",    sec1, 0);
        chk("c5_rst_convsw", conv_sw1, 0);
        chk("c5_rst_cf",     cf1, 0);
        chk("c5_rst_done",   done1, 0);

        // Case 3: saturation on the MAX_SEC=10 instance
        sw = 8'h09;
        start2 = 1'b1; cyc(); start2 = 1'b0;
        repeat (9) tick_period();
        chk("c3_sec9", sec2, 9);
        chk("c3_run", st2, 1);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("c3_sec10",  sec2, 10);
        chk("c3_ovf",    ovf2, 1);
        chk("c3_settle", st2, 2);
        cyc();
        cyc();
        chk("c3_done", done2, 1);
        chk("c3_cf",   cf2, 2);
        repeat (5) tick_period();
        chk("c3_sec_hold", sec2, 10);
        chk("c3_ovf_hold", ovf2, 1);

        // Case 6: restart after an overflowed session
        sw = 8'h41;
        start2 = 1'b1; cyc(); start2 = 1'b0;
        chk("c6_state",  st2, 1);
        chk("c6_sec",    sec2, 0);
        chk("c6_ovf",    ovf2, 0);
        chk("c6_convsw", conv_sw2, 8'h41);
        chk("c6_cf",     cf2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
